// File: rtl/root_uplink_arbiter_pkg.sv
// Shared constants and width helpers for the uplink/downlink arbitration blocks.
package root_uplink_arbiter_pkg;

    localparam int CHANNEL_WIDTH_DEFAULT = 64;

    // Index width for n items; a single item still needs one bit to carry a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Rotate-priority encoder: first asserted request at or after start, wrapping.
module rr_pick_next
    import root_uplink_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0] w_pos;

    // Scan from the far end toward start so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, start} + (W + 1)'(k);
            if (w_pos >= (W + 1)'(N)) begin
                w_pos = w_pos - (W + 1)'(N);
            end
            if (req[w_pos]) begin
                idx = w_pos[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/root_uplink_arbiter.sv
// Round-robin merge of NUM_SOURCES ready/valid uplinks into one registered
// output, holding a grant for up to MAX_BURST consecutive words.
module root_uplink_arbiter
    import root_uplink_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES   = 4,
    parameter int CHANNEL_WIDTH = CHANNEL_WIDTH_DEFAULT,
    parameter int MAX_BURST     = 4,
    parameter int SRC_WIDTH     = idx_width(NUM_SOURCES)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [CHANNEL_WIDTH*NUM_SOURCES-1:0] in_data,
    input  logic [NUM_SOURCES-1:0]               in_valid,
    output logic [NUM_SOURCES-1:0]               in_ready,
    output logic [CHANNEL_WIDTH-1:0]             out_data,
    output logic [SRC_WIDTH-1:0]                 out_src,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SRC_WIDTH-1:0]                 busy_grant
);

    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

    logic [SRC_WIDTH-1:0]     r_g;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic                     r_lock;
    logic [CHANNEL_WIDTH-1:0] r_out_data;
    logic [SRC_WIDTH-1:0]     r_out_src;
    logic                     r_out_valid;

    logic [SRC_WIDTH-1:0]     w_start;
    logic [SRC_WIDTH-1:0]     w_pick;
    logic                     w_pick_any;
    logic [SRC_WIDTH-1:0]     w_sel;
    logic                     w_hold;
    logic                     w_slot_free;
    logic                     w_accept;
    logic [CNT_WIDTH-1:0]     w_cnt_next;

    // Search begins just past the last grant so the last grantee is checked last.
    assign w_start = (r_g == SRC_WIDTH'(NUM_SOURCES - 1)) ? '0 : r_g + SRC_WIDTH'(1);

    rr_pick_next #(
        .N (NUM_SOURCES),
        .W (SRC_WIDTH)
    ) u_pick (
        .req   (in_valid),
        .start (w_start),
        .idx   (w_pick),
        .any   (w_pick_any)
    );

    assign w_hold      = r_lock && in_valid[r_g];
    assign w_sel       = w_hold ? r_g : w_pick;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = w_slot_free && w_pick_any;
    assign w_cnt_next  = w_hold ? r_cnt + CNT_WIDTH'(1) : CNT_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_ready
            assign in_ready[gi] = w_accept && !reset && (w_sel == SRC_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_g         <= SRC_WIDTH'(NUM_SOURCES - 1);
            r_cnt       <= '0;
            r_lock      <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= in_data[CHANNEL_WIDTH*w_sel +: CHANNEL_WIDTH];
            r_out_src   <= w_sel;
            r_out_valid <= 1'b1;
            r_g         <= w_sel;
            r_cnt       <= w_cnt_next;
            r_lock      <= (w_cnt_next < CNT_WIDTH'(MAX_BURST));
        end else if (w_slot_free) begin
            // Slot free but nothing valid: drain the register and release any lock.
            r_out_valid <= 1'b0;
            r_lock      <= 1'b0;
        end
    end

    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign out_valid  = r_out_valid;
    assign busy_grant = r_g;

endmodule

// File: tb/tb_root_uplink_arbiter.sv
// Scoreboard bench for root_uplink_arbiter: MAX_BURST=4 and MAX_BURST=1 instances
// share stimulus; use1 selects which one is observed.
module tb_root_uplink_arbiter;

    localparam int N  = 4;
    localparam int CW = 64;
    localparam int SW = 2;

    typedef struct {
        logic [SW-1:0] src;
        logic [CW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*CW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic            out_ready;
    logic            use1;

    logic [N-1:0]  in_ready0, in_ready1;
    logic [CW-1:0] out_data0, out_data1;
    logic [SW-1:0] out_src0, out_src1, bg0, bg1;
    logic          out_valid0, out_valid1;

    logic [N-1:0]  w_in_ready;
    logic [CW-1:0] w_out_data;
    logic [SW-1:0] w_out_src;
    logic          w_out_valid;

    assign w_in_ready  = use1 ? in_ready1  : in_ready0;
    assign w_out_data  = use1 ? out_data1  : out_data0;
    assign w_out_src   = use1 ? out_src1   : out_src0;
    assign w_out_valid = use1 ? out_valid1 : out_valid0;

    always #5 clk = ~clk;

    root_uplink_arbiter #(.NUM_SOURCES(N), .CHANNEL_WIDTH(CW), .MAX_BURST(4)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_src(out_src0),
        .out_valid(out_valid0), .out_ready(out_ready), .busy_grant(bg0)
    );

    root_uplink_arbiter #(.NUM_SOURCES(N), .CHANNEL_WIDTH(CW), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_src(out_src1),
        .out_valid(out_valid1), .out_ready(out_ready), .busy_grant(bg1)
    );

    logic [N-1:0] en;
    int           rem  [N];
    int           kcnt [N];
    exp_t         sbq [$];
    logic [SW-1:0] log_src [$];
    logic [CW-1:0] log_data [$];
    int            log_cyc [$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [CW-1:0] hold_data;
    logic [SW-1:0] hold_src;

    function automatic logic [CW-1:0] word_of(input int s, input int k);
        return {32'(s), 32'(s * 16 + k)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            in_valid[s]          = en[s] && (rem[s] > 0);
            in_data[s*CW +: CW]  = word_of(s, kcnt[s]);
        end
    endtask

    task automatic clear_log();
        log_src.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    // One cycle: drive at negedge, observe handshakes #1 later, advance to next negedge.
    task automatic step();
        exp_t e;
        drive();
        #1;
        chk("in_ready_onehot0", $onehot0(w_in_ready), 1);
        if (w_out_valid && out_ready) begin
            $display("out cyc=%0d src=%0d data=%h", cyc, w_out_src, w_out_data);
            if (sbq.size() == 0) begin
                chk("sb_qsize", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk("sb_src", w_out_src, e.src);
                chk("sb_data", w_out_data, e.data);
            end
            log_src.push_back(w_out_src);
            log_data.push_back(w_out_data);
            log_cyc.push_back(cyc);
        end
        for (int s = 0; s < N; s++) begin
            if (in_valid[s] && w_in_ready[s]) begin
                e.src  = SW'(s);
                e.data = word_of(s, kcnt[s]);
                sbq.push_back(e);
                rem[s]--;
                kcnt[s]++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Assert reset at a negedge and verify the asynchronous clear before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", w_out_valid, 0);
        chk("rst_in_ready", w_in_ready, 0);
        chk("rst_out_data", w_out_data, 0);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        en = '0;
        for (int s = 0; s < N; s++) begin
            rem[s]  = 0;
            kcnt[s] = 0;
        end
        drive();
        clear_log();
    endtask

    task automatic drain();
        en = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("sb_drain", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        use1 = 1'b0;
        out_ready = 1'b1;
        en = '0;
        for (int s = 0; s < N; s++) begin
            rem[s]  = 0;
            kcnt[s] = 0;
        end
        drive();
        @(negedge clk);
        do_reset();

        // Idle after reset, then reset during traffic.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_out_valid", w_out_valid, 0);
            chk("idle_in_ready", w_in_ready, 0);
        end
        en[0] = 1'b1;
        rem[0] = 100;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_valid", w_out_valid, 1);
        drive();
        do_reset();

        // Single source 2, ten words back to back.
        en[2] = 1'b1;
        rem[2] = 10;
        for (int i = 0; i < 14; i++) step();
        chk("t2_count", log_src.size(), 10);
        if (log_src.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk("t2_src", log_src[i], 2);
                chk("t2_data", log_data[i], 64'h0000_0002_0000_0020 + 64'(i));
            end
            chk("t2_no_bubble", log_cyc[9] - log_cyc[0], 9);
        end
        drain();

        // All sources valid, bursts of four in rotation.
        do_reset();
        en = '1;
        for (int s = 0; s < N; s++) rem[s] = 1000;
        for (int i = 0; i < 24; i++) step();
        chk("t3_count_ge20", log_src.size() >= 20, 1);
        if (log_src.size() >= 20) begin
            for (int i = 0; i < 20; i++) chk("t3_src_seq", log_src[i], (i / 4) % 4);
            chk("t3_no_bubble", log_cyc[19] - log_cyc[0], 19);
        end
        drain();

        // MAX_BURST=1: sources 0 and 3 alternate.
        use1 = 1'b1;
        do_reset();
        en[0] = 1'b1; en[3] = 1'b1;
        rem[0] = 100; rem[3] = 100;
        for (int i = 0; i < 10; i++) step();
        chk("t4_count_ge8", log_src.size() >= 8, 1);
        if (log_src.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk("t4_alt", log_src[i], (i % 2 == 0) ? 0 : 3);
        end
        drain();
        use1 = 1'b0;

        // Locked source 1 drops valid once; source 3 takes over with no bubble.
        do_reset();
        en[1] = 1'b1; en[3] = 1'b1;
        rem[1] = 100; rem[3] = 100;
        step();
        step();
        en[1] = 1'b0;
        step();
        en[1] = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("t5_count_ge8", log_src.size() >= 8, 1);
        if (log_src.size() >= 8) begin
            chk("t5_s0", log_src[0], 1);
            chk("t5_s1", log_src[1], 1);
            for (int i = 2; i < 6; i++) chk("t5_burst3", log_src[i], 3);
            chk("t5_s6", log_src[6], 1);
            chk("t5_s7", log_src[7], 1);
            chk("t5_no_bubble", log_cyc[7] - log_cyc[0], 7);
        end
        drain();

        // Back-pressure freeze, then random valid/ready traffic.
        do_reset();
        en = '1;
        for (int s = 0; s < N; s++) rem[s] = 100000;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        chk("t6_stall_valid", w_out_valid, 1);
        hold_data = w_out_data;
        hold_src  = w_out_src;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_stall_data", w_out_data, hold_data);
            chk("t6_stall_src", w_out_src, hold_src);
            chk("t6_stall_in_ready", w_in_ready, 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            en        = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/root_uplink_arbiter.md
Name: root_uplink_arbiter

Overview:
Round-robin arbiter with burst hold that merges NUM_SOURCES 64-bit ready/valid uplink channels into one registered output channel.
- Sources are the local controller channel and the leaf rx FIFOs.
- The output feeds the root hub core's single rx port, or the parent link.
- Each output word carries the index of the source it came from.
- Bounded bursts keep multi-word messages contiguous without starving other sources.

Parameters:
NUM_SOURCES, 4, number of input channels (>=1)
CHANNEL_WIDTH, 64, data width per channel
MAX_BURST, 4, maximum consecutive words granted to one source (>=1; 1 = pure round-robin)
SRC_WIDTH, derived = max(1, clog2(NUM_SOURCES)), width of source index

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-high
in_data  input  CHANNEL_WIDTH*NUM_SOURCES  source i occupies [CHANNEL_WIDTH*i +: CHANNEL_WIDTH]
in_valid  input  NUM_SOURCES  per-source valid
in_ready  output  NUM_SOURCES  per-source ready, at most one bit set
out_data  output  CHANNEL_WIDTH  registered word
out_src  output  SRC_WIDTH  index of the source of out_data
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts
busy_grant  output  SRC_WIDTH  current/last granted source (debug)

Behaviour:
- Reset values (asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - grant register g=NUM_SOURCES-1, so the first search starts at 0.
  - burst counter cnt=0, lock=0.
  - in_ready=0 while reset is asserted.
- slot_free = !out_valid || out_ready.
- Selection, combinational, each cycle:
  - If lock && in_valid[g]: sel=g.
  - Else: sel = first i with in_valid[i], scanning g+1, g+2, ... wrapping modulo NUM_SOURCES and ending at g (g is checked last).
  - any = at least one in_valid bit set.
- in_ready[sel] = slot_free && any; all other in_ready bits = 0.
  - No combinational path from in_valid to in_ready of a different source beyond the scan; no path from out_ready to out_valid.
- Accept, posedge, when slot_free && any:
  - out_data <= in_data[sel]; out_src <= sel; out_valid <= 1; g <= sel.
  - If sel==g && lock: cnt <= cnt+1. Otherwise cnt <= 1 (new grant).
  - lock <= (new cnt < MAX_BURST).
- No accept: if out_ready, out_valid <= 0.
  - A locked source that drops valid loses its lock (lock <= 0) in the first cycle it is observed invalid while the slot is free.
  - Arbitration among the others happens in that same cycle; no bubble.
- Latency and throughput:
  - 1 cycle from input handshake to out_valid.
  - Sustained 1 word/cycle while out_ready=1.
  - Back-pressure (out_ready=0 with out_valid=1) freezes g, cnt, lock and out_* exactly.
- Burst end: when cnt reaches MAX_BURST, the next search starts at g+1. The same source wins again only if no other source is valid; cnt then restarts at 1.
- Fairness: any continuously valid source is served within (NUM_SOURCES-1)*MAX_BURST accepted words.
- Simultaneous out_ready and new accept in one cycle: the register is replaced; no drop, no duplicate.
- NUM_SOURCES=1: always sel=0; cnt still counts but has no effect.
- Reset mid-operation: the word in the output register is discarded; source-side words not yet handshaked are retained by their FIFOs.
- cnt width = clog2(MAX_BURST+1); cnt never exceeds MAX_BURST.

Decomposition:
- Shared package: CHANNEL_WIDTH default and the derived-width helper (clog2/max).
- One natural sub-module: rr_pick_next.
  - Combinational rotate-priority encoder: inputs req vector and start index; outputs index and any.
  - Reusable by the downlink broadcast side.
- The rest (output register, g/cnt/lock) stays in root_uplink_arbiter.

Test Plan:
1. Reset then all idle, out_ready=1 -> out_valid=0 and in_ready=0 indefinitely. Assert reset mid-stream -> out_valid drops to 0 the same time, before the next edge.
2. NUM_SOURCES=4, MAX_BURST=4, only source 2 valid with words 0x20..0x29, out_ready=1 -> ten consecutive output words 0x20..0x29, one per cycle, out_src=2, no bubbles.
3. All four sources continuously valid, MAX_BURST=4 -> out_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., each source's data in order.
4. MAX_BURST=1, sources 0 and 3 valid -> out_src alternates 0,3,0,3.
5. Source 1 locked (cnt=2) drops valid for one cycle while source 3 is valid -> next word from source 3 with no empty cycle; source 1 resumes only after source 3's burst.
6. out_ready held 0 for 5 cycles with out_valid=1 -> out_data/out_src stable, in_ready=0. On release -> the next word appears the following cycle, none lost or duplicated (scoreboard over 1000 random valid/ready cycles).
